// File: rtl/tx_escaper.sv
// Transmit-path escaper: turns upstream words into a continuous line stream,
// filling gaps with IDLE_WORD and escaping payload words that collide with IDLE/ESC.
module tx_escaper #(
  parameter int unsigned                WR_WIDTH  = 12,
  parameter logic [WR_WIDTH-1:0]        IDLE_WORD = 12'h7FE,
  parameter logic [WR_WIDTH-1:0]        ESC_WORD  = 12'h7FD,
  parameter logic [WR_WIDTH-1:0]        ESC_MASK  = 12'h020,
  parameter int unsigned                CNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_enable,
  input  logic                  in_en,
  input  logic [WR_WIDTH-1:0]   in_data,
  output logic                  out_idle,
  output logic [WR_WIDTH-1:0]   out_data,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  esc_cnt
);

  typedef enum logic {
    NORMAL = 1'b0,
    ESC2   = 1'b1
  } state_t;

  state_t                 state_q;
  logic [WR_WIDTH-1:0]    out_data_q;
  logic [WR_WIDTH-1:0]    pend_data_q;
  logic                   out_err_q;
  logic [CNT_WIDTH-1:0]   esc_cnt_q;
  logic                   collide;

  // Ready depends only on the state register so the upstream valid cannot loop back.
  assign out_idle = (state_q == NORMAL);
  assign collide  = (in_data == IDLE_WORD) || (in_data == ESC_WORD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= NORMAL;
      out_data_q  <= IDLE_WORD;
      pend_data_q <= '0;
      out_err_q   <= 1'b0;
      esc_cnt_q   <= '0;
    end else if (in_enable) begin
      case (state_q)
        NORMAL: begin
          if (in_en) begin
            if (collide) begin
              out_data_q  <= ESC_WORD;
              pend_data_q <= in_data ^ ESC_MASK;
              state_q     <= ESC2;
              if (esc_cnt_q != '1) begin
                esc_cnt_q <= esc_cnt_q + 1'b1;
              end
            end else begin
              out_data_q <= in_data;
            end
          end else begin
            out_data_q <= IDLE_WORD;
          end
        end
        ESC2: begin
          out_data_q <= pend_data_q;
          state_q    <= NORMAL;
          if (in_en) begin
            out_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= NORMAL;
        end
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_err  = out_err_q;
  assign esc_cnt  = esc_cnt_q;

endmodule

// File: tb/tb_tx_escaper.sv
// Scoreboard bench for tx_escaper: expected line words queued by the stimulus,
// popped and compared by a monitor after every enabled clock edge.
module tb_tx_escaper;

  logic        clock;
  logic        reset_n;
  logic        in_enable;
  logic        in_en;
  logic [11:0] in_data;
  logic        out_idle;
  logic [11:0] out_data;
  logic        out_err;
  logic [1:0]  esc_cnt;

  int unsigned checks;
  int unsigned failures;
  logic [11:0] sb[$];
  logic [11:0] up[$];

  tx_escaper #(
    .WR_WIDTH (12),
    .IDLE_WORD(12'h7FE),
    .ESC_WORD (12'h7FD),
    .ESC_MASK (12'h020),
    .CNT_WIDTH(2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_enable(in_enable),
    .in_en    (in_en),
    .in_data  (in_data),
    .out_idle (out_idle),
    .out_data (out_data),
    .out_err  (out_err),
    .esc_cnt  (esc_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one line word is produced per enabled edge.
  always @(posedge clock) begin
    logic samp;
    logic [11:0] e;
    samp = in_enable && reset_n;
    #1;
    if (samp) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got %h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("line_word", {4'h0, out_data}, {4'h0, e});
      end
    end
  end

  task automatic cyc(input logic e, input logic v, input logic [11:0] d);
    in_enable = e;
    in_en     = v;
    in_data   = d;
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    in_enable = 1'b0;
    in_en     = 1'b0;
    in_data   = '0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    in_enable = 1'b0;
    in_en    = 1'b0;
    in_data  = '0;
    #1;
    do_reset();

    // 1: idle fill after reset
    chk("rst_out_data", {4'h0, out_data}, 16'h07FE);
    chk("rst_out_idle", {15'h0, out_idle}, 16'h1);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(12'h7FE);
      cyc(1'b1, 1'b0, 12'h000);
      chk("idle_out_idle", {15'h0, out_idle}, 16'h1);
    end
    chk("idle_esc_cnt", {14'h0, esc_cnt}, 16'h0);
    chk("idle_out_err", {15'h0, out_err}, 16'h0);

    // 2: non-colliding stream
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(12'(i));
      cyc(1'b1, 1'b1, 12'(i));
      chk("stream_out_idle", {15'h0, out_idle}, 16'h1);
    end
    sb.push_back(12'h7FE);
    cyc(1'b1, 1'b0, 12'h000);

    // 3: single colliding word
    sb.push_back(12'h7FD);
    cyc(1'b1, 1'b1, 12'h7FE);
    chk("esc2_out_idle", {15'h0, out_idle}, 16'h0);
    sb.push_back(12'h7DE);
    cyc(1'b1, 1'b0, 12'h000);
    chk("after_esc_out_idle", {15'h0, out_idle}, 16'h1);
    chk("single_esc_cnt", {14'h0, esc_cnt}, 16'h1);
    sb.push_back(12'h7FE);
    cyc(1'b1, 1'b0, 12'h000);

    // 4: upstream honours out_idle, back-to-back colliding words
    do_reset();
    up.push_back(12'h7FD);
    up.push_back(12'h7FE);
    up.push_back(12'h100);
    sb.push_back(12'h7FD);
    sb.push_back(12'h7DD);
    sb.push_back(12'h7FD);
    sb.push_back(12'h7DE);
    sb.push_back(12'h100);
    sb.push_back(12'h7FE);
    for (int i = 0; i < 6; i++) begin
      if (out_idle && up.size() != 0) cyc(1'b1, 1'b1, up.pop_front());
      else cyc(1'b1, 1'b0, 12'h000);
    end
    chk("b2b_all_sent", 16'(up.size()), 16'h0);
    chk("b2b_esc_cnt", {14'h0, esc_cnt}, 16'h2);
    chk("b2b_out_err", {15'h0, out_err}, 16'h0);

    // 5: protocol violation during ESC2
    sb.push_back(12'h7FD);
    cyc(1'b1, 1'b1, 12'h7FD);
    sb.push_back(12'h7DD);
    cyc(1'b1, 1'b1, 12'h055);
    chk("viol_out_err", {15'h0, out_err}, 16'h1);
    sb.push_back(12'h7FE);
    cyc(1'b1, 1'b0, 12'h000);
    sb.push_back(12'h7FE);
    cyc(1'b1, 1'b0, 12'h000);
    chk("viol_err_sticky", {15'h0, out_err}, 16'h1);

    // 6: freeze mid-escape, async reset, then counter saturation
    do_reset();
    chk("err_cleared", {15'h0, out_err}, 16'h0);
    sb.push_back(12'h7FD);
    cyc(1'b1, 1'b1, 12'h7FE);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 12'h055);
      chk("frozen_out_data", {4'h0, out_data}, 16'h07FD);
      chk("frozen_out_idle", {15'h0, out_idle}, 16'h0);
    end
    in_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_data", {4'h0, out_data}, 16'h07FE);
    chk("async_rst_out_idle", {15'h0, out_idle}, 16'h1);
    chk("async_rst_esc_cnt", {14'h0, esc_cnt}, 16'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(12'h7FD);
      cyc(1'b1, 1'b1, 12'h7FE);
      sb.push_back(12'h7DE);
      cyc(1'b1, 1'b0, 12'h000);
      chk("sat_esc_cnt", {14'h0, esc_cnt}, (i >= 3) ? 16'h3 : 16'(i));
    end
    sb.push_back(12'h7FE);
    cyc(1'b1, 1'b0, 12'h000);
    in_enable = 1'b0;
    @(posedge clock);
    #2;
    chk("sb_drained", 16'(sb.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
